// File: rtl/hsk_pulse_scheduler.sv
// hsk_pulse_scheduler: round-robin sharing of one pulse synchronizer among NB_REQ event requesters
module hsk_pulse_scheduler #(
    parameter int NB_REQ = 4,
    parameter int CNT_W = 4,
    parameter int BUSY_TMO = 8,
    localparam int ID_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1,
    localparam int TMO_W = $clog2(BUSY_TMO + 1)
) (
    input  logic              aclk_i,
    input  logic              srst_i,
    input  logic [NB_REQ-1:0] req_i,
    input  logic              ovf_clr_i,
    input  logic              tready_i,
    output logic              tvalid_o,
    output logic [ID_W-1:0]   id_o,
    output logic              busy_o,
    output logic [NB_REQ-1:0] ovf_o,
    output logic              err_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
    state_t state, state_nxt;
    logic [CNT_W-1:0] cnt [NB_REQ];
    logic [CNT_W-1:0] cnt_nxt [NB_REQ];
    logic [NB_REQ-1:0] pend, ovf_set;
    logic [ID_W-1:0] last, gnt_id;
    logic [TMO_W-1:0] tmo;
    logic found, grant, tmo_hit;
    assign tvalid_o = state == ISSUE;
    assign busy_o = state != IDLE;
    always_comb begin
        pend = '0;
        for (int i = 0; i < NB_REQ; i++) pend[i] = cnt[i] != '0;
    end
    // first pending requester after the last one served, wrapping around
    always_comb begin
        found = 1'b0;
        gnt_id = '0;
        for (int i = 1; i <= NB_REQ; i++) begin
            if (!found && pend[(int'(last) + i) % NB_REQ]) begin
                found = 1'b1;
                gnt_id = ID_W'((int'(last) + i) % NB_REQ);
            end
        end
    end
    always_comb begin
        state_nxt = state;
        grant = 1'b0;
        tmo_hit = 1'b0;
        case (state)
            IDLE: if (found && tready_i) begin
                grant = 1'b1;
                state_nxt = ISSUE;
            end
            ISSUE: state_nxt = WAIT_BUSY;
            WAIT_BUSY: if (!tready_i) state_nxt = WAIT_DONE;
                else if (tmo == TMO_W'(BUSY_TMO - 1)) begin
                    tmo_hit = 1'b1;
                    state_nxt = IDLE;
                end
            WAIT_DONE: if (tready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    // a same-edge event and grant cancel out, so saturation only drops unmatched events
    always_comb begin
        cnt_nxt = cnt;
        ovf_set = '0;
        for (int k = 0; k < NB_REQ; k++) begin
            ovf_set[k] = req_i[k] && !(grant && gnt_id == ID_W'(k)) && &cnt[k];
            cnt_nxt[k] = (req_i[k] && !(grant && gnt_id == ID_W'(k)) && !ovf_set[k]) ? cnt[k] + 1'b1 :
                         (!req_i[k] && grant && gnt_id == ID_W'(k)) ? cnt[k] - 1'b1 : cnt[k];
        end
    end
    always_ff @(posedge aclk_i) begin
        if (srst_i) begin
            state <= IDLE;
            last <= ID_W'(NB_REQ - 1);
            id_o <= '0;
            tmo <= '0;
            ovf_o <= '0;
            err_o <= 1'b0;
            for (int k = 0; k < NB_REQ; k++) cnt[k] <= '0;
        end else begin
            state <= state_nxt;
            tmo <= (state == ISSUE) ? '0 : (state == WAIT_BUSY) ? tmo + 1'b1 : tmo;
            if (grant) begin
                last <= gnt_id;
                id_o <= gnt_id;
            end
            ovf_o <= (ovf_clr_i ? '0 : ovf_o) | ovf_set;
            err_o <= (err_o && !ovf_clr_i) || tmo_hit;
            for (int k = 0; k < NB_REQ; k++) cnt[k] <= cnt_nxt[k];
        end
    end
endmodule

// File: tb/tb_hsk_pulse_scheduler.sv
// tb_hsk_pulse_scheduler: directed stimulus with a transaction-level scheduler model and a modelled synchronizer
module tb_hsk_pulse_scheduler;
    localparam int NB = 4;
    localparam int CW = 2;
    localparam int TMO = 8;
    localparam int MAXC = (1 << CW) - 1;
    logic aclk_i = 1'b0;
    logic srst_i, ovf_clr_i;
    logic tready_i = 1'b1;
    logic [NB-1:0] req_i;
    logic tvalid_o, busy_o, err_o;
    logic [1:0] id_o;
    logic [NB-1:0] ovf_o;
    int n_cmp = 0;
    int n_bad = 0;
    bit started = 0;
    logic [1:0] glog [$];
    hsk_pulse_scheduler #(.NB_REQ(NB), .CNT_W(CW), .BUSY_TMO(TMO)) dut (
        .aclk_i(aclk_i), .srst_i(srst_i), .req_i(req_i), .ovf_clr_i(ovf_clr_i),
        .tready_i(tready_i), .tvalid_o(tvalid_o), .id_o(id_o), .busy_o(busy_o),
        .ovf_o(ovf_o), .err_o(err_o)
    );
    always #5 aclk_i = ~aclk_i;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    task automatic tick();
        @(negedge aclk_i);
    endtask
    // synchronizer: drops tready one cycle after a pulse, raises it lat cycles later
    int sync_mode = 1;
    bit force_val = 1'b1;
    int lat = 10;
    int hold = 0;
    bit pend_drop = 1'b0;
    always begin
        @(negedge aclk_i);
        #2;
        if (sync_mode == 1) begin
            tready_i = force_val;
            pend_drop = 1'b0;
        end else begin
            if (pend_drop) begin
                tready_i = 1'b0;
                hold = lat;
                pend_drop = 1'b0;
            end else if (!tready_i) begin
                if (hold <= 1) tready_i = 1'b1;
                else hold--;
            end
            if (tvalid_o) pend_drop = 1'b1;
        end
    end
    // model: pending counts, fair pick, and a transfer that ends on handshake or timeout
    int m_cnt [NB];
    int m_last, m_id, m_age, g;
    bit m_xfer, m_low, m_err;
    logic [NB-1:0] m_ovf;
    always @(posedge aclk_i) begin
        if (srst_i) begin
            foreach (m_cnt[k]) m_cnt[k] = 0;
            m_last = NB - 1;
            m_id = 0;
            m_xfer = 0;
            m_err = 0;
            m_ovf = '0;
        end else begin
            g = -1;
            if (!m_xfer && tready_i)
                for (int i = 1; i <= NB; i++)
                    if (g < 0 && m_cnt[(m_last + i) % NB] > 0) g = (m_last + i) % NB;
            if (ovf_clr_i) begin
                m_ovf = '0;
                m_err = 0;
            end
            if (m_xfer) begin
                if (m_age > 0) begin
                    if (m_low) begin
                        if (tready_i) m_xfer = 0;
                    end else if (!tready_i) m_low = 1;
                    else if (m_age == TMO) begin
                        m_err = 1;
                        m_xfer = 0;
                    end
                end
                m_age++;
            end
            for (int k = 0; k < NB; k++) begin
                if (req_i[k] && k != g) begin
                    if (m_cnt[k] == MAXC) m_ovf[k] = 1'b1;
                    else m_cnt[k]++;
                end else if (!req_i[k] && k == g) m_cnt[k]--;
            end
            if (g >= 0) begin
                m_xfer = 1;
                m_age = 0;
                m_low = 0;
                m_last = g;
                m_id = g;
            end
        end
    end
    always @(negedge aclk_i) begin
        if (started) begin
            chk("tvalid", tvalid_o, m_xfer && m_age == 0);
            chk("busy", busy_o, m_xfer);
            chk("id", id_o, m_id);
            chk("ovf", ovf_o, m_ovf);
            chk("err", err_o, m_err);
            if (tvalid_o) glog.push_back(id_o);
        end
    end
    task automatic wait_drain();
        int n;
        n = 0;
        while (n < 300 && (busy_o || m_cnt[0] + m_cnt[1] + m_cnt[2] + m_cnt[3] != 0 || !tready_i)) begin
            tick();
            n++;
        end
        chk("drain_timeout", n < 300, 1);
    endtask
    task automatic clear_flags();
        ovf_clr_i = 1'b1;
        tick();
        ovf_clr_i = 1'b0;
    endtask
    initial begin
        srst_i = 1'b1;
        req_i = 4'hF;
        ovf_clr_i = 1'b0;
        tick();
        started = 1;
        tick();
        tick();
        chk("rst_tvalid", tvalid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_id", id_o, 0);
        chk("rst_ovf", ovf_o, 0);
        chk("rst_err", err_o, 0);
        srst_i = 1'b0;
        req_i = '0;
        tick();
        // round robin: everyone once, then requester 0 hammering
        sync_mode = 0;
        lat = 3;
        glog.delete();
        req_i = 4'hF;
        tick();
        req_i = 4'b0001;
        repeat (8) tick();
        req_i = '0;
        for (int n = 0; n < 200 && glog.size() < 5; n++) tick();
        chk("rr_count", glog.size() >= 5, 1);
        if (glog.size() >= 5) begin
            chk("rr_0", glog[0], 0);
            chk("rr_1", glog[1], 1);
            chk("rr_2", glog[2], 2);
            chk("rr_3", glog[3], 3);
            chk("rr_4", glog[4], 0);
        end
        wait_drain();
        chk("rr_ovf", ovf_o, 4'b0001);
        clear_flags();
        chk("rr_ovf_clr", ovf_o, 0);
        // single event
        glog.delete();
        lat = 10;
        req_i = 4'b0100;
        tick();
        req_i = '0;
        chk("se_pre", tvalid_o, 0);
        tick();
        chk("se_tvalid", tvalid_o, 1);
        chk("se_id", id_o, 2);
        chk("se_busy", busy_o, 1);
        tick();
        chk("se_width", tvalid_o, 0);
        wait_drain();
        chk("se_pulses", glog.size(), 1);
        // saturation with the channel held busy
        sync_mode = 1;
        force_val = 1'b0;
        tick();
        glog.delete();
        repeat (5) begin
            req_i = 4'b0010;
            tick();
        end
        req_i = '0;
        chk("sat_cnt", m_cnt[1], 3);
        chk("sat_ovf", ovf_o, 4'b0010);
        chk("sat_none", glog.size(), 0);
        sync_mode = 0;
        lat = 2;
        wait_drain();
        chk("sat_pulses", glog.size(), 3);
        foreach (glog[i]) chk("sat_id", glog[i], 1);
        clear_flags();
        chk("sat_ovf_clr", ovf_o, 0);
        // event on the grant edge of the same requester
        glog.delete();
        req_i = 4'b0001;
        tick();
        tick();
        req_i = '0;
        chk("sim_cnt", m_cnt[0], 1);
        wait_drain();
        chk("sim_pulses", glog.size(), 2);
        if (glog.size() == 2) begin
            chk("sim_id0", glog[0], 0);
            chk("sim_id1", glog[1], 0);
        end
        // lost handshake, then the next pending event goes through
        sync_mode = 1;
        force_val = 1'b1;
        tick();
        req_i = 4'b1100;
        tick();
        req_i = '0;
        tick();
        chk("tmo_tvalid", tvalid_o, 1);
        chk("tmo_id", id_o, 2);
        repeat (8) tick();
        chk("tmo_early", err_o, 0);
        tick();
        chk("tmo_err", err_o, 1);
        chk("tmo_idle", busy_o, 0);
        sync_mode = 0;
        tick();
        chk("tmo_next", tvalid_o, 1);
        chk("tmo_next_id", id_o, 3);
        wait_drain();
        chk("tmo_sticky", err_o, 1);
        clear_flags();
        chk("tmo_clr", err_o, 0);
        // reset in the middle of a transfer with an event still pending
        req_i = 4'b0001;
        tick();
        tick();
        req_i = '0;
        chk("mid_tvalid", tvalid_o, 1);
        srst_i = 1'b1;
        tick();
        srst_i = 1'b0;
        chk("mid_tvalid_rst", tvalid_o, 0);
        chk("mid_busy_rst", busy_o, 0);
        repeat (20) tick();
        chk("mid_discard", busy_o, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
